gray_rx: RTL and testbench
==========================

GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 3: bit width of the Gray-code input and the decoded value (legal range 2..8).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port En, input, 1 bit: sample strobe; Gray is captured only on edges where En=1.
REQ-005 SHALL have port Clr, input, 1 bit: synchronous resynchronise request.
REQ-006 SHALL have port Gray, input, WIDTH bits: incoming reflected-binary Gray code.
REQ-007 SHALL have port Bin, output reg, WIDTH bits: last accepted decoded binary value.
REQ-008 SHALL have port Step, output reg, 1 bit: one-cycle pulse on each accepted single-step change.
REQ-009 SHALL have port Dir, output reg, 1 bit: direction of the last accepted step (1 = up, 0 = down).
REQ-010 SHALL have port Overflow, output reg, 1 bit: sticky; set on an up-step from all-ones to zero.
REQ-011 SHALL have port Err, output reg, 1 bit: sticky; set on an illegal transition.
REQ-012 SHALL have port Locked, output, 1 bit: high while the state is TRACK.

Function
REQ-013 SHALL decode Gray to binary as b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i]; the decoder is combinational, but Bin is registered.
REQ-014 SHALL implement three states: IDLE, TRACK and FAULT.
REQ-015 In IDLE, when En=1, SHALL load Bin with the decoded value and enter TRACK; no Step is produced.
REQ-016 In TRACK with En=1, when decoded == Bin+1 mod 2^WIDTH, SHALL update Bin, pulse Step and set Dir=1.
REQ-017 In TRACK with En=1, when decoded == Bin-1 mod 2^WIDTH, SHALL update Bin, pulse Step and set Dir=0 (subject to REQ-029).
REQ-018 In TRACK with En=1, when decoded == Bin, SHALL hold all state, produce no Step and leave Dir unchanged.
REQ-019 In TRACK with En=1, for any other decoded value, SHALL set Err, leave Bin unchanged, produce no Step and enter FAULT.
REQ-020 SHALL set Overflow on an up-step from 2^WIDTH-1 to 0; a down-step from 0 to 2^WIDTH-1 is legal and does not affect Overflow.
REQ-021 In FAULT, SHALL ignore En and hold Bin, Err and Overflow.
REQ-022 When Clr=1 in any state, SHALL clear Err and Overflow, deassert Step, keep Bin and enter IDLE; Clr has priority over En on the same edge.
REQ-023 Step SHALL be high for exactly the one cycle after an accepting edge; with consecutive accepted samples it stays high continuously.
REQ-024 Latency SHALL be one cycle: an En sample at edge N is reflected in the outputs after edge N.
REQ-025 En=0 SHALL leave all state unchanged and deassert Step.

Reset
REQ-026 Reset=1 SHALL immediately (asynchronously) set state=IDLE, Bin=0, Step=0, Dir=1, Overflow=0 and Err=0.
REQ-027 Reset asserted mid-operation (TRACK or FAULT) SHALL discard all history; the first En sample after release is treated per REQ-015.
REQ-028 Reset SHALL take priority over Clr and En.

Configuration
REQ-029 Macro GRAY_RX_DOWN_EN SHALL control down-step handling: when defined, down-steps are accepted per REQ-017; when undefined, a down-step is illegal and handled per REQ-019, and Dir is held at 1.

Verification
REQ-030 Reset, then En=1 with Gray sequence 000,001,011,010 (WIDTH=3) -> Bin 0,1,2,3; Step high on the last three samples; Dir=1; Err=0.
REQ-031 Up-run from binary 6: Gray 101,100,000 -> Bin 6,7,0; Overflow=1 after the 100->000 sample; Step pulses continue.
REQ-032 In TRACK at Bin=3 (Gray 010), apply Gray 110 (binary 4? no: jump to 4 is legal) then Gray 000 (binary 0 from 4) -> Err=1, state FAULT, Bin stays 4; further En samples ignored.
REQ-033 With GRAY_RX_DOWN_EN defined, Bin=2 then Gray 001 -> Bin=1, Dir=0, Step pulse; without the macro, the same stimulus -> Err=1 and Bin=2.
REQ-034 In FAULT, Clr=1 together with En=1 and Gray 111 -> Err=0 and state IDLE; the next En sample with Gray 111 -> Bin=5, Locked=1, no Step.
REQ-035 Reset pulsed asynchronously between clock edges while Bin=5 -> Bin=0, Err=0 and Overflow=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/gray_rx.sv
// gray_rx: registered Gray-code receiver with single-step tracking.
//
// Decodes a reflected-binary Gray input. A sample is taken only on rising
// edges where En=1. The first sample after reset or Clr is loaded as is. After
// that, only single-step moves are accepted. Any other jump raises a sticky
// error and parks the block in FAULT until Clr is asserted.
//
// Build option: define GRAY_RX_DOWN_EN to accept down-steps. When it is
// undefined, a down-step counts as an illegal transition and Dir stays at 1.
//
// Ports:
//   Clk      - clock, rising edge
//   Reset    - asynchronous active-high reset
//   En       - sample strobe
//   Clr      - synchronous resynchronise request (clears Err/Overflow, -> IDLE)
//   Gray     - Gray-code input, WIDTH bits
//   Bin      - last accepted decoded value
//   Step     - one-cycle pulse per accepted step
//   Dir      - direction of last accepted step (1 = up)
//   Overflow - sticky, set on up-step from all-ones to zero
//   Err      - sticky, set on an illegal transition
//   Locked   - high while tracking
module gray_rx #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Clr,
   input  logic [WIDTH-1:0] Gray,
   output logic [WIDTH-1:0] Bin,
   output logic             Step,
   output logic             Dir,
   output logic             Overflow,
   output logic             Err,
   output logic             Locked
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StTrack = 2'd1;
   localparam logic [1:0] StFault = 2'd2;

   localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] Ones = {WIDTH{1'b1}};

`ifdef GRAY_RX_DOWN_EN
   localparam bit DownEn = 1'b1;
`else
   localparam bit DownEn = 1'b0;
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] dec;
   logic [WIDTH-1:0] bin_inc;
   logic [WIDTH-1:0] bin_dec;

   // Binary bit i is the XOR of all Gray bits from i up to the MSB.
   always_comb begin
      dec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dec[i] = ^(Gray >> i);
      end
   end

   assign bin_inc = bin_q + One;
   assign bin_dec = bin_q - One;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      step_d  = 1'b0;
      dir_d   = dir_q;
      ovf_d   = ovf_q;
      err_d   = err_q;

      if (Clr) begin
         // Clr wins over En on the same edge; Bin is deliberately kept.
         state_d = StIdle;
         ovf_d   = 1'b0;
         err_d   = 1'b0;
      end else if (En) begin
         unique case (state_q)
            StIdle: begin
               bin_d   = dec;
               state_d = StTrack;
            end
            StTrack: begin
               if (dec == bin_inc) begin
                  bin_d  = dec;
                  step_d = 1'b1;
                  dir_d  = 1'b1;
                  if (bin_q == Ones) begin
                     ovf_d = 1'b1;
                  end
               end else if (dec == bin_q) begin
                  // Repeated sample: nothing moves.
               end else if (DownEn && (dec == bin_dec)) begin
                  bin_d  = dec;
                  step_d = 1'b1;
                  dir_d  = 1'b0;
               end else begin
                  err_d   = 1'b1;
                  state_d = StFault;
               end
            end
            default: begin
               // FAULT (and unused codes) ignore samples until Clr.
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         bin_q   <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b1;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign Bin      = bin_q;
   assign Step     = step_q;
   assign Dir      = dir_q;
   assign Overflow = ovf_q;
   assign Err      = err_q;
   assign Locked   = (state_q == StTrack);

endmodule

// File: tb/tb_gray_rx.sv
// Testbench for gray_rx (WIDTH=3): directed scenarios followed by random
// stimulus. The driver updates a behavioural model and queues the expected
// outputs. A monitor pops one entry after each clock edge and compares it
// with the DUT outputs.
module tb_gray_rx;

   localparam int W = 3;
   localparam int M = 1 << W;

`ifdef GRAY_RX_DOWN_EN
   localparam bit DownEn = 1'b1;
`else
   localparam bit DownEn = 1'b0;
`endif

   logic         Clk = 1'b0;
   logic         Reset;
   logic         En;
   logic         Clr;
   logic [W-1:0] Gray;
   logic [W-1:0] Bin;
   logic         Step;
   logic         Dir;
   logic         Overflow;
   logic         Err;
   logic         Locked;

   gray_rx #(.WIDTH(W)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .En       (En),
      .Clr      (Clr),
      .Gray     (Gray),
      .Bin      (Bin),
      .Step     (Step),
      .Dir      (Dir),
      .Overflow (Overflow),
      .Err      (Err),
      .Locked   (Locked)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int bin;
      bit step;
      bit dir;
      bit ovf;
      bit err;
      bit lock;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Model state: 0 = idle, 1 = track, 2 = fault.
   int m_state, m_bin;
   bit m_step, m_dir, m_ovf, m_err;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray_of(input int v);
      return v ^ (v >> 1);
   endfunction

   function automatic int g2b(input int g);
      int b = 0;
      for (int k = 0; k < W; k++) b ^= g >> k;
      return b % M;
   endfunction

   task automatic model_reset();
      m_state = 0; m_bin = 0; m_step = 0; m_dir = 1; m_ovf = 0; m_err = 0;
   endtask

   task automatic model_step(input bit en, input bit clr, input int g);
      int d;
      d = g2b(g);
      m_step = 0;
      if (clr) begin
         m_err = 0; m_ovf = 0; m_state = 0;
      end else if (en && m_state == 0) begin
         m_bin = d; m_state = 1;
      end else if (en && m_state == 1) begin
         if (d == (m_bin + 1) % M) begin
            if (m_bin == M - 1) m_ovf = 1;
            m_bin = d; m_step = 1; m_dir = 1;
         end else if (d == m_bin) begin
         end else if (DownEn && d == (m_bin + M - 1) % M) begin
            m_bin = d; m_step = 1; m_dir = 0;
         end else begin
            m_err = 1; m_state = 2;
         end
      end
   endtask

   // One clock of stimulus; the expectation applies after the next rising edge.
   task automatic cycle(input bit en, input bit clr, input int g);
      exp_t e;
      @(negedge Clk);
      En = en; Clr = clr; Gray = W'(g);
      model_step(en, clr, g);
      e.bin = m_bin; e.step = m_step; e.dir = m_dir;
      e.ovf = m_ovf; e.err = m_err; e.lock = (m_state == 1);
      sb.push_back(e);
   endtask

   task automatic check_reset_now(input string tag);
      chk({tag, ".Bin"}, int'(Bin), 0);
      chk({tag, ".Step"}, int'(Step), 0);
      chk({tag, ".Dir"}, int'(Dir), 1);
      chk({tag, ".Overflow"}, int'(Overflow), 0);
      chk({tag, ".Err"}, int'(Err), 0);
      chk({tag, ".Locked"}, int'(Locked), 0);
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic async_reset(input string tag);
      @(negedge Clk);
      En = 0; Clr = 0;
      #2 Reset = 1;
      #1 check_reset_now(tag);
      model_reset();
      @(negedge Clk);
      Reset = 0;
   endtask

   // Monitor: compare one queued expectation after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("Bin", int'(Bin), e.bin);
            chk("Step", int'(Step), int'(e.step));
            chk("Dir", int'(Dir), int'(e.dir));
            chk("Overflow", int'(Overflow), int'(e.ovf));
            chk("Err", int'(Err), int'(e.err));
            chk("Locked", int'(Locked), int'(e.lock));
         end
      end
   end

   initial begin
      int r, v, g;
      Reset = 1; En = 0; Clr = 0; Gray = '0;
      model_reset();
      #3 check_reset_now("reset");
      @(negedge Clk);
      Reset = 0;

      // Load then count up 0..3.
      cycle(1, 0, 3'b000);
      cycle(1, 0, 3'b001);
      cycle(1, 0, 3'b011);
      cycle(1, 0, 3'b010);
      // Legal step to 4, then illegal jump to 0 -> FAULT; samples ignored.
      cycle(1, 0, 3'b110);
      cycle(1, 0, 3'b000);
      cycle(1, 0, 3'b111);
      cycle(0, 0, 3'b111);
      // Clr beats En, then reload at 5.
      cycle(1, 1, 3'b111);
      cycle(1, 0, 3'b111);
      // Up-run 6, 7, 0 with wrap overflow; En=0 holds.
      cycle(1, 0, 3'b101);
      cycle(1, 0, 3'b100);
      cycle(1, 0, 3'b000);
      cycle(0, 0, 3'b000);
      cycle(1, 0, 3'b000);
      // Down-step 2 -> 1 (legal only with the build option).
      cycle(1, 1, 3'b000);
      cycle(1, 0, 3'b011);
      cycle(1, 0, 3'b001);
      // Down-wrap 0 -> 7 must not touch Overflow.
      cycle(1, 1, 3'b000);
      cycle(1, 0, 3'b000);
      cycle(1, 0, 3'b100);
      // Back to Bin=5 with some history, then asynchronous reset.
      cycle(1, 1, 3'b000);
      cycle(1, 0, 3'b111);
      async_reset("async_reset");
      cycle(1, 0, 3'b010);

      // Random phase.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rand_reset");
         end else begin
            r = $urandom_range(0, 9);
            if (r < 4)      v = (m_bin + 1) % M;
            else if (r < 7) v = (m_bin + M - 1) % M;
            else if (r < 8) v = m_bin;
            else            v = $urandom_range(0, M - 1);
            g = gray_of(v);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, g);
         end
      end

      @(negedge Clk);
      En = 0; Clr = 0;
      @(negedge Clk);
      chk("queue_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
